// File: rtl/demux_cb.sv
// ---------------------------------------------------------------------------
// demux_cb -- registered 1-to-4 demultiplexer for single-bit condition values
//
// A producer pushes one bit per cycle toward the channel named by `selector`.
// Each of the four channels is a small circular FIFO. Each consumer drains its
// own channel independently through a valid/ready handshake.
//
// Parameters
//   DEPTH        entries per channel FIFO; a power of two, 2..8
//
// Ports
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   selector     destination channel of the current input bit
//   data_in      bit to route
//   in_valid     producer offers data_in this cycle
//   in_ready     block accepts the input this cycle
//   data_0..3    head bit of channel k, 0 while channel k is empty
//   out_valid    bit k set while channel k holds at least one bit
//   out_ready    bit k set when consumer k takes its head this cycle
//   overrun      sticky per-channel overrun flags
//   overrun_clr  clears every overrun flag at the next edge
//
// Optional feature
//   DEMUX_CB_OVERRUN_EN  when defined, a push is never refused. A push into a
//                        full channel with no pop drops that channel's oldest
//                        bit and sets its overrun flag. When undefined, a full
//                        channel backpressures the producer, overrun reads 0000
//                        and overrun_clr is ignored.
// ---------------------------------------------------------------------------
module demux_cb #(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] selector,
   input  logic       data_in,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       data_0,
   output logic       data_1,
   output logic       data_2,
   output logic       data_3,
   output logic [3:0] out_valid,
   input  logic [3:0] out_ready,
   output logic [3:0] overrun,
   input  logic       overrun_clr
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DEPTH-1:0] mem    [4];
   logic [PW-1:0]    wr_ptr [4];
   logic [PW-1:0]    rd_ptr [4];
   logic [CW-1:0]    count  [4];

   logic [3:0] empty;
   logic [3:0] full;
   logic [3:0] head;
   logic [3:0] push;
   logic [3:0] pop;
   logic [3:0] drop;
   logic [3:0] adv_rd;

   // Channel status and masked head read.
   // NOTE: every variable in this block is assigned on every pass, so no latch
   // can be inferred; keep it that way when adding outputs here.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         empty[k] = (count[k] == '0);
         full[k]  = (count[k] == FULL_CNT);
         head[k]  = empty[k] ? 1'b0 : mem[k][rd_ptr[k]];
      end
   end

`ifdef DEMUX_CB_OVERRUN_EN
   assign in_ready = 1'b1;
`else
   // Looks only at the selected channel's fill level, never at out_ready, so
   // a full channel cannot accept a bit even while its consumer is popping.
   assign in_ready = !full[selector];
`endif

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         push[k] = in_valid & in_ready & (selector == 2'(k));
         pop[k]  = !empty[k] & out_ready[k];
`ifdef DEMUX_CB_OVERRUN_EN
         // Push into a full channel with no pop: the oldest bit makes room.
         drop[k] = push[k] & full[k] & !pop[k];
`else
         drop[k] = 1'b0;
`endif
         adv_rd[k] = pop[k] | drop[k];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 4; k++) begin
            // NOTE: storage is cleared on reset as well; it is only a few flops
            // and a just-reset channel then holds no stale bits.
            mem[k]    <= '0;
            wr_ptr[k] <= '0;
            rd_ptr[k] <= '0;
            count[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
               mem[k][wr_ptr[k]] <= data_in;
               wr_ptr[k]         <= wr_ptr[k] + 1'b1;
            end
            if (adv_rd[k]) begin
               rd_ptr[k] <= rd_ptr[k] + 1'b1;
            end
            // A drop is a push paired with a read advance, so the count holds.
            unique case ({push[k], adv_rd[k]})
               2'b10:   count[k] <= count[k] + 1'b1;
               2'b01:   count[k] <= count[k] - 1'b1;
               default: count[k] <= count[k];
            endcase
         end
      end
   end

`ifdef DEMUX_CB_OVERRUN_EN
   // Set wins over clear when an overrun lands in the clearing cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun <= '0;
      end else begin
         overrun <= (overrun_clr ? 4'b0000 : overrun) | drop;
      end
   end
`else
   logic unused_overrun_clr;
   assign unused_overrun_clr = overrun_clr;
   assign overrun = 4'b0000;
`endif

   assign out_valid = ~empty;
   assign data_0    = head[0];
   assign data_1    = head[1];
   assign data_2    = head[2];
   assign data_3    = head[3];

endmodule

// File: tb/tb_demux_cb.sv
// ---------------------------------------------------------------------------
// tb_demux_cb -- self-checking bench for demux_cb (DEPTH = 2)
//
// A queue-per-channel reference model tracks the expected contents. Before
// every clock edge, all DUT outputs are compared with the model. The edge's
// push/pop/drop is then applied to the model. Directed sequences come first,
// followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_demux_cb;

   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] selector;
   logic       data_in;
   logic       in_valid;
   logic       in_ready;
   logic       data_0, data_1, data_2, data_3;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [3:0] overrun;
   logic       overrun_clr;

   int errors = 0;
   int checks = 0;

   // Reference model: one queue of bits per channel plus the sticky flags.
   bit         q [4][$];
   logic [3:0] ovr_m;

   demux_cb #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .selector    (selector),
      .data_in     (data_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .data_0      (data_0),
      .data_1      (data_1),
      .data_2      (data_2),
      .data_3      (data_3),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_in_ready();
`ifdef DEMUX_CB_OVERRUN_EN
      return 1'b1;
`else
      return q[selector].size() < DEPTH;
`endif
   endfunction

   task automatic compare_outputs(input string tag);
      logic [3:0] ev;
      logic [3:0] ed;
      logic [3:0] gd;
      for (int k = 0; k < 4; k++) begin
         ev[k] = (q[k].size() != 0);
         ed[k] = ev[k] ? q[k][0] : 1'b0;
      end
      gd = {data_3, data_2, data_1, data_0};
      check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
      check({tag, ".data"},      32'(gd),        32'(ed));
      check({tag, ".in_ready"},  32'(in_ready),  32'(exp_in_ready()));
      check({tag, ".overrun"},   32'(overrun),   32'(ovr_m));
   endtask

   // Apply one cycle: drive, compare before the edge, update the model, clock.
   task automatic step(input string tag, input logic [1:0] sel, input logic din,
                       input logic vld, input logic [3:0] ordy, input logic clr);
      logic       acc;
      logic [3:0] drop;
      selector    = sel;
      data_in     = din;
      in_valid    = vld;
      out_ready   = ordy;
      overrun_clr = clr;
      #2;
      compare_outputs(tag);
      acc  = vld && exp_in_ready();
      drop = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         if (ordy[k] && q[k].size() != 0) begin
            void'(q[k].pop_front());
         end else if (acc && sel == 2'(k) && q[k].size() == DEPTH) begin
            void'(q[k].pop_front());
            drop[k] = 1'b1;
         end
      end
      if (acc) q[sel].push_back(din);
`ifdef DEMUX_CB_OVERRUN_EN
      ovr_m = (clr ? 4'b0000 : ovr_m) | drop;
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int k = 0; k < 4; k++) q[k].delete();
      ovr_m = 4'b0000;
   endtask

   initial begin
      clear_model();
      reset_n     = 1'b0;
      selector    = 2'd0;
      data_in     = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 4'b0000;
      overrun_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.out_valid", 32'(out_valid), 32'h0);
      check("rst.in_ready",  32'(in_ready),  32'h1);
      reset_n = 1'b1;

      // Idle after release.
      for (int i = 0; i < 3; i++) step("idle", 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);

      // Routing: channel 2 then channel 0.
      step("route_a", 2'd2, 1'b1, 1'b1, 4'h0, 1'b0);
      step("route_b", 2'd0, 1'b1, 1'b1, 4'h0, 1'b0);
      step("route_c", 2'd1, 1'b0, 1'b0, 4'h0, 1'b0);
      check("route.out_valid", 32'(out_valid), 32'h5);
      step("drain", 2'd0, 1'b0, 1'b0, 4'hf, 1'b0);

      // Fill channel 3 and hold the input against backpressure.
      step("fill_a", 2'd3, 1'b1, 1'b1, 4'h0, 1'b0);
      step("fill_b", 2'd3, 1'b0, 1'b1, 4'h0, 1'b0);
      step("fill_c", 2'd3, 1'b1, 1'b1, 4'h0, 1'b0);
      step("fill_d", 2'd1, 1'b0, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) step("pop3", 2'd0, 1'b0, 1'b0, 4'h8, 1'b0);

      // Simultaneous push and pop on channel 0.
      step("sim_a", 2'd0, 1'b1, 1'b1, 4'h0, 1'b0);
      step("sim_b", 2'd0, 1'b0, 1'b1, 4'h1, 1'b0);
      step("sim_c", 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
      step("sim_d", 2'd0, 1'b0, 1'b0, 4'h1, 1'b0);

      // Three pushes into channel 2 with no pops, then drain and clear.
      step("ovr_a", 2'd2, 1'b1, 1'b1, 4'h0, 1'b0);
      step("ovr_b", 2'd2, 1'b0, 1'b1, 4'h0, 1'b0);
      step("ovr_c", 2'd2, 1'b1, 1'b1, 4'h0, 1'b0);
      step("ovr_d", 2'd2, 1'b0, 1'b0, 4'h4, 1'b0);
      step("ovr_e", 2'd2, 1'b0, 1'b0, 4'h4, 1'b0);
      step("ovr_f", 2'd2, 1'b0, 1'b0, 4'h0, 1'b1);
      step("ovr_g", 2'd2, 1'b0, 1'b0, 4'h0, 1'b0);

      // Asynchronous reset while bits are queued.
      step("pre_rst_a", 2'd1, 1'b1, 1'b1, 4'h0, 1'b0);
      step("pre_rst_b", 2'd3, 1'b1, 1'b1, 4'h0, 1'b0);
      reset_n = 1'b0;
      #1;
      clear_model();
      compare_outputs("async_rst");
      check("async_rst.data3", 32'(data_3), 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step("post_rst", 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);

      // Randomized traffic; wraps pointers many times on every channel.
      for (int i = 0; i < 3000; i++) begin
         step("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 7) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demux_cb.md
# demux_cb

Registered 1-to-4 demultiplexer for single-bit condition values: routes `data_in` to one of four output channels chosen by a 2-bit `selector`, with a small per-channel FIFO and valid/ready handshakes on both sides. It is the inverse of the 4:1 condition-bit mux. A producer, such as the ALU flag path, pushes a bit toward channel k. Each consumer (branch unit, status register, exception logic, debug tap) pops bits from its own channel independently.

## Interface
- `DEPTH`, default 2: entries per channel FIFO. Must be a power of two, 2..8; any other value is unsupported.
- `clk`  in  1: single clock, all state updates on the rising edge.
- `reset_n`  in  1: asynchronous reset, active-low.
- `selector`  in  2: destination channel for the current input bit.
- `data_in`  in  1: bit to route.
- `in_valid`  in  1: producer has a bit on `data_in`.
- `in_ready`  out  1: block accepts the input this cycle.
- `data_0`..`data_3`  out  1 each: head entry of channel k; 0 when channel k is empty.
- `out_valid`  out  4: bit k set when channel k is non-empty.
- `out_ready`  in  4: bit k set when consumer k takes its head this cycle.
- `overrun`  out  4: sticky per-channel overrun flags. Tied to 0 when `DEMUX_CB_OVERRUN_EN` is undefined.
- `overrun_clr`  in  1: clears all `overrun` bits. Ignored without the macro.

## Operation
- Four independent circular FIFOs, each `DEPTH` x 1 bit, with write pointer, read pointer and occupancy count.
- Pointers have width log2(`DEPTH`) and wrap modulo `DEPTH`. The count is log2(`DEPTH`)+1 bits wide, range 0..`DEPTH`.
- Push: when `in_valid & in_ready`, write `data_in` into the FIFO selected by `selector`. Advance its write pointer and increment its count.
- Pop on channel k: when `out_valid[k] & out_ready[k]`, advance its read pointer and decrement its count. All four channels can pop in the same cycle.
- Push and pop on the same non-full channel in the same cycle: both take effect and the count is unchanged.
- `out_ready[k]` while channel k is empty has no effect.
- `in_ready` is combinational: it equals `!full[selector]`. It does not depend on `out_ready`, so there is no same-cycle pass-through into a full channel.
- `data_k` is the combinational read of the head of FIFO k, masked to 0 when the FIFO is empty.
- The input side has no internal state machine. Each channel occupies states EMPTY (count 0), PARTIAL (0 < count < `DEPTH`) or FULL (count = `DEPTH`), and moves between them only by push/pop as above.

## Timing
- Reset (`reset_n` low, asynchronous assert, synchronous release on `clk`): all counts and pointers go to 0. Outputs: `out_valid`=0000, `data_0..3`=0, `in_ready`=1, `overrun`=0000. FIFO storage is cleared to 0.
- Reset asserted mid-operation discards all queued bits immediately, without waiting for a clock edge.
- Latency: a push at edge N appears on `data_k`/`out_valid[k]` after edge N, i.e. usable in cycle N+1 when the channel was empty.
- Order within a channel is strict FIFO. Bits pushed to different channels have no ordering relation.
- A pop at edge N exposes the next entry, or 0 with `out_valid[k]`=0, after edge N.
- The producer may change `selector` every cycle. `in_ready` follows `selector` in the same cycle.

## Configuration
- `DEMUX_CB_OVERRUN_EN` undefined (default): the backpressure mode described above. `overrun` is held at 0000 and `overrun_clr` is ignored.
- `DEMUX_CB_OVERRUN_EN` defined: `in_ready` is constantly 1 after reset, and a push is never refused.
  - Push to a FULL channel k with a simultaneous pop on k: normal push and pop.
  - Push to a FULL channel k without a pop: the oldest entry is dropped (read pointer advances) and the new bit is written. The count stays `DEPTH` and `overrun[k]` is set.
  - `overrun_clr` clears all flags at the next edge. If a new overrun on k occurs in the same cycle as the clear, `overrun[k]` ends up set (set wins).

## Test plan
- Reset and idle: assert `reset_n`=0 mid-stream with data queued -> all outputs read zero (`out_valid`=0000, `data_0..3`=0, `overrun`=0000) and `in_ready`=1 before the next edge. After release, idle with no pushes -> outputs stay at those values.
- Routing: push 1 to sel=2, then 1 to sel=0, `out_ready`=0000 -> `out_valid`=0101, `data_2`=1, `data_0`=1, `data_1`=`data_3`=0, each visible one cycle after its push.
- Fill and backpressure (`DEPTH`=2, no macro): push 1 then 0 to sel=3, hold `in_valid` with sel=3 -> `in_ready`=0. Switch sel to 1 -> `in_ready`=1. Pop ch3 twice -> `data_3` reads 1, then 0, then `out_valid[3]`=0.
- Simultaneous push/pop: channel 0 holds one bit (1); push 0 to sel=0 while `out_ready[0]`=1 -> count stays 1 and `data_0`=0 next cycle.
- Wrap-around: `DEPTH`=4, run 10 push/pop pairs of alternating bits on channel 1 -> output sequence exactly matches input, with no loss across pointer wrap.
- Overrun (macro defined, `DEPTH`=2): push 1, 0, 1 to sel=2 with no pops -> `in_ready` stays 1, `overrun`=0100, and pops yield 0 then 1. Pulse `overrun_clr` -> `overrun`=0000.
